// File: rtl/fb_pkg.sv
// Shared constants, command op codes and engine state encoding for the
// framebuffer port arbiter.
package fb_pkg;
    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int AW    = 11;
    localparam int DW    = 9;
    localparam int CELLS = COLS * ROWS;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_CLR    = 2'b01;
    localparam logic [1:0] OP_SCROLL = 2'b10;

    localparam logic [AW-1:0] A_COLS    = AW'(COLS);
    localparam logic [AW-1:0] A_LAST    = AW'(CELLS - 1);
    localparam logic [AW-1:0] A_SC_LAST = AW'(COLS * (ROWS - 1) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SC_RD,
        ST_SC_WAIT,
        ST_SC_WR,
        ST_FILL
    } eng_state_t;
endpackage

// File: rtl/fb_port_arb_if.sv
// Bundle of video, host, engine-command and RAM signals around the arbiter.
// slave = the arbiter itself, master = requesters plus the RAM.
interface fb_port_arb_if;
    import fb_pkg::*;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_fill;
    logic          cmd_ready;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata,
               cmd_valid, cmd_op, cmd_fill, ram_rdata,
        output vid_data, vid_valid, host_ack, host_rdata, cmd_ready, busy,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata,
               cmd_valid, cmd_op, cmd_fill, ram_rdata,
        input  vid_data, vid_valid, host_ack, host_rdata, cmd_ready, busy,
               ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_fill_engine.sv
// Clear / scroll-up engine: walks the visible framebuffer one RAM slot at a
// time, requesting the slot from the arbiter and advancing only on grant.
module fb_fill_engine
    import fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cmd_valid,
    input  logic [1:0]    i_cmd_op,
    input  logic [DW-1:0] i_cmd_fill,
    output logic          o_cmd_ready,
    output logic          o_req,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    input  logic          i_gnt,
    input  logic          i_rvalid,
    input  logic [DW-1:0] i_rdata
);
    eng_state_t    r_state, w_state_nxt;
    logic [AW-1:0] r_a, w_a_nxt;
    logic [DW-1:0] r_fill, w_fill_nxt;
    logic [DW-1:0] r_cell, w_cell_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
        end
        r_fill <= w_fill_nxt;
        r_cell <= w_cell_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_fill_nxt  = r_fill;
        w_cell_nxt  = r_cell;
        o_cmd_ready = (r_state == ST_IDLE);
        o_req       = 1'b0;
        o_we        = 1'b0;
        o_addr      = r_a;
        o_wdata     = r_fill;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_fill_nxt = i_cmd_fill;
                    w_a_nxt    = '0;
                    if (i_cmd_op == OP_CLR)
                        w_state_nxt = ST_CLR;
                    else if (i_cmd_op == OP_SCROLL)
                        w_state_nxt = ST_SC_RD;
                end
            end
            ST_CLR, ST_FILL: begin
                o_req = 1'b1;
                o_we  = 1'b1;
                if (i_gnt) begin
                    w_a_nxt = r_a + 1'b1;
                    if (r_a == A_LAST)
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_SC_RD: begin
                o_req  = 1'b1;
                o_addr = r_a + A_COLS;
                if (i_gnt)
                    w_state_nxt = ST_SC_WAIT;
            end
            // No slot request while the source row cell is still in flight.
            ST_SC_WAIT: begin
                if (i_rvalid) begin
                    w_cell_nxt  = i_rdata;
                    w_state_nxt = ST_SC_WR;
                end
            end
            ST_SC_WR: begin
                o_req   = 1'b1;
                o_we    = 1'b1;
                o_wdata = r_cell;
                if (i_gnt) begin
                    w_a_nxt     = r_a + 1'b1;
                    w_state_nxt = (r_a == A_SC_LAST) ? ST_FILL : ST_SC_RD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: rtl/fb_port_arb.sv
// Single-port framebuffer RAM arbiter: video has fixed priority with a fixed
// two-cycle latency; host and the fill engine round-robin the leftover slots.
module fb_port_arb
    import fb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fb_port_arb_if.slave bus
);
    logic          w_cmd_ready, w_eng_req, w_eng_we;
    logic [AW-1:0] w_eng_addr, w_addr;
    logic [DW-1:0] w_eng_wdata, w_wdata;
    logic          w_host_elig, w_gnt_vid, w_gnt_host, w_gnt_eng, w_we;

    logic          r_rr_host;
    logic [AW-1:0] r_ram_addr_p1;
    logic          r_ram_we_p1;
    logic [DW-1:0] r_ram_wdata_p1;
    logic          r_vid_vld_p1, r_host_vld_p1, r_host_rd_p1, r_eng_rd_p1;
    logic          r_vid_vld_p2, r_host_vld_p2, r_host_rd_p2, r_eng_rd_p2;

    fb_fill_engine u_eng (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (bus.cmd_valid),
        .i_cmd_op    (bus.cmd_op),
        .i_cmd_fill  (bus.cmd_fill),
        .o_cmd_ready (w_cmd_ready),
        .o_req       (w_eng_req),
        .o_we        (w_eng_we),
        .o_addr      (w_eng_addr),
        .o_wdata     (w_eng_wdata),
        .i_gnt       (w_gnt_eng),
        .i_rvalid    (r_eng_rd_p2),
        .i_rdata     (bus.ram_rdata)
    );

    // Stage p0: grant decision. r_rr_host=1 means host wins a tie.
    always_comb begin
        w_host_elig = bus.host_req && !r_host_vld_p1 && !r_host_vld_p2;
        w_gnt_vid   = bus.vid_req;
        w_gnt_host  = !bus.vid_req && w_host_elig && (!w_eng_req || r_rr_host);
        w_gnt_eng   = !bus.vid_req && w_eng_req && (!w_host_elig || !r_rr_host);
        w_addr      = w_eng_addr;
        w_we        = w_gnt_eng && w_eng_we;
        w_wdata     = w_eng_wdata;
        if (w_gnt_vid) begin
            w_addr = bus.vid_addr;
        end else if (w_gnt_host) begin
            w_addr  = bus.host_addr;
            w_we    = bus.host_we;
            w_wdata = bus.host_wdata;
        end
    end

    // Stage p1: RAM command registers; stage p2: read data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_host      <= 1'b1;
            r_ram_addr_p1  <= '0;
            r_ram_we_p1    <= 1'b0;
            r_ram_wdata_p1 <= '0;
            r_vid_vld_p1   <= 1'b0;
            r_host_vld_p1  <= 1'b0;
            r_host_rd_p1   <= 1'b0;
            r_eng_rd_p1    <= 1'b0;
            r_vid_vld_p2   <= 1'b0;
            r_host_vld_p2  <= 1'b0;
            r_host_rd_p2   <= 1'b0;
            r_eng_rd_p2    <= 1'b0;
        end else begin
            if (w_gnt_host)
                r_rr_host <= 1'b0;
            else if (w_gnt_eng)
                r_rr_host <= 1'b1;
            r_ram_addr_p1  <= w_addr;
            r_ram_we_p1    <= w_we;
            r_ram_wdata_p1 <= w_wdata;
            r_vid_vld_p1   <= w_gnt_vid;
            r_host_vld_p1  <= w_gnt_host;
            r_host_rd_p1   <= w_gnt_host && !bus.host_we;
            r_eng_rd_p1    <= w_gnt_eng && !w_eng_we;
            r_vid_vld_p2   <= r_vid_vld_p1;
            r_host_vld_p2  <= r_host_vld_p1;
            r_host_rd_p2   <= r_host_rd_p1;
            r_eng_rd_p2    <= r_eng_rd_p1;
        end
    end

    assign bus.ram_addr   = r_ram_addr_p1;
    assign bus.ram_we     = r_ram_we_p1;
    assign bus.ram_wdata  = r_ram_wdata_p1;
    assign bus.vid_valid  = r_vid_vld_p2;
    assign bus.vid_data   = r_vid_vld_p2 ? bus.ram_rdata : '0;
    assign bus.host_ack   = r_host_vld_p2;
    assign bus.host_rdata = r_host_rd_p2 ? bus.ram_rdata : '0;
    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.busy       = !w_cmd_ready;
endmodule
